icache_refill: RTL and testbench

Miss-side fill engine feeding the byte-wide direct-mapped instruction cache.
- On an IF-stage miss, reads the 4 instruction bytes from the 8-bit RAM port.
- Writes each byte into the cache through its write port.
- Returns the assembled 32-bit little-endian instruction to IF.
- Sits between IF, the icache write port and the memory arbiter.

---
 rtl/icache_refill.sv | 205 ++++++++++++++++++++
 tb/tb_icache_refill.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache miss fill engine; optional next-line prefetch under ICACHE_PREFETCH_EN
module icache_refill #(
  parameter int ADDR_W     = 32,
  parameter int FILL_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              flush_i,
  input  logic              mem_busy_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_din_i,
  output logic              cache_we_o,
  output logic [ADDR_W-1:0] cache_waddr_o,
  output logic [7:0]        cache_wdata_o,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic              busy_o
);

  localparam logic [2:0] LAST_ISSUE = 3'(FILL_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1
`ifdef ICACHE_PREFETCH_EN
    , PREFETCH = 2'd2
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [2:0]          issue_cnt_q, issue_cnt_d;
  logic [1:0]          recv_cnt_q, recv_cnt_d;
  logic                data_vld_q, data_vld_d;
  logic                done_q, done_d;
  logic [31:0]         bytes_q, bytes_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic                mem_rd_q, mem_rd_d;
  logic                cache_we_q, cache_we_d;
  logic [ADDR_W-1:0]   cache_waddr_q, cache_waddr_d;
  logic [7:0]          cache_wdata_q, cache_wdata_d;
  logic [31:0]         inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;

  logic                accept;
  logic                start;
  state_t              start_state;
  logic [ADDR_W-1:0]   start_base;
  logic [ADDR_W-1:0]   req_base;

  // Address low bits are masked off so every fill starts on a word boundary.
  assign req_base = req_addr_i & ~ADDR_W'(3);
  assign accept   = req_i && !mem_busy_i && !flush_i;

  // Next-state logic: everything holds while rdy is low; one-cycle strobes clear otherwise.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    issue_cnt_d   = issue_cnt_q;
    recv_cnt_d    = recv_cnt_q;
    data_vld_d    = data_vld_q;
    done_d        = done_q;
    bytes_d       = bytes_q;
    mem_a_d       = mem_a_q;
    mem_rd_d      = mem_rd_q;
    cache_we_d    = cache_we_q;
    cache_waddr_d = cache_waddr_q;
    cache_wdata_d = cache_wdata_q;
    inst_d        = inst_q;
    inst_valid_d  = inst_valid_q;
    start         = 1'b0;
    start_state   = FETCH;
    start_base    = req_base;

    if (rdy) begin
      mem_rd_d     = 1'b0;
      cache_we_d   = 1'b0;
      inst_valid_d = 1'b0;
      data_vld_d   = 1'b0;
      done_d       = 1'b0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            start = 1'b1;
          end
        end
        default: begin
          if (flush_i) begin
            state_d     = IDLE;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 2'd0;
          end
`ifdef ICACHE_PREFETCH_EN
          else if (state_q == PREFETCH && (req_i || mem_busy_i)) begin
            state_d     = IDLE;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 2'd0;
            if (accept) begin
              start = 1'b1;
            end
          end
`endif
          else begin
            // Read data returns one cycle after its address was presented.
            data_vld_d = mem_rd_q;
            if (issue_cnt_q < LAST_ISSUE) begin
              mem_a_d     = base_q + ADDR_W'(issue_cnt_q);
              mem_rd_d    = 1'b1;
              issue_cnt_d = issue_cnt_q + 3'd1;
            end
            if (data_vld_q) begin
              cache_we_d    = 1'b1;
              cache_waddr_d = base_q + ADDR_W'(recv_cnt_q);
              cache_wdata_d = mem_din_i;
              bytes_d[{recv_cnt_q, 3'b000} +: 8] = mem_din_i;
              recv_cnt_d    = recv_cnt_q + 2'd1;
              if (recv_cnt_q == 2'd3) begin
                done_d = 1'b1;
                if (state_q == FETCH) begin
                  inst_d       = {mem_din_i, bytes_q[23:0]};
                  inst_valid_d = 1'b1;
                end
              end
            end
            // The cycle carrying the last write is the final busy cycle.
            if (done_q) begin
              state_d     = IDLE;
              issue_cnt_d = 3'd0;
              recv_cnt_d  = 2'd0;
`ifdef ICACHE_PREFETCH_EN
              if (state_q == FETCH && !req_i && !mem_busy_i) begin
                start       = 1'b1;
                start_state = PREFETCH;
                start_base  = base_q + ADDR_W'(4);
              end
`endif
            end
          end
        end
      endcase

      if (start) begin
        state_d     = start_state;
        base_d      = start_base;
        mem_a_d     = start_base;
        mem_rd_d    = 1'b1;
        issue_cnt_d = 3'd1;
        recv_cnt_d  = 2'd0;
        data_vld_d  = 1'b0;
        done_d      = 1'b0;
      end
    end
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      issue_cnt_q   <= 3'd0;
      recv_cnt_q    <= 2'd0;
      data_vld_q    <= 1'b0;
      done_q        <= 1'b0;
      bytes_q       <= 32'd0;
      mem_a_q       <= '0;
      mem_rd_q      <= 1'b0;
      cache_we_q    <= 1'b0;
      cache_waddr_q <= '0;
      cache_wdata_q <= 8'd0;
      inst_q        <= 32'd0;
      inst_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      issue_cnt_q   <= issue_cnt_d;
      recv_cnt_q    <= recv_cnt_d;
      data_vld_q    <= data_vld_d;
      done_q        <= done_d;
      bytes_q       <= bytes_d;
      mem_a_q       <= mem_a_d;
      mem_rd_q      <= mem_rd_d;
      cache_we_q    <= cache_we_d;
      cache_waddr_q <= cache_waddr_d;
      cache_wdata_q <= cache_wdata_d;
      inst_q        <= inst_d;
      inst_valid_q  <= inst_valid_d;
    end
  end

  // Strobes are masked during a stall so a held event fires once, when rdy returns.
  assign mem_a_o       = mem_a_q;
  assign mem_rd_o      = mem_rd_q & rdy;
  assign cache_we_o    = cache_we_q & rdy;
  assign cache_waddr_o = cache_waddr_q;
  assign cache_wdata_o = cache_wdata_q;
  assign inst_o        = inst_q;
  assign inst_valid_o  = inst_valid_q & rdy;
  assign busy_o        = (state_q == FETCH);

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - randomized bench for icache_refill against a phase-level reference model
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        mem_busy_i = 1'b0;
  logic [7:0]  mem_din_i = 8'd0;
  logic [31:0] mem_a_o;
  logic        mem_rd_o;
  logic        cache_we_o;
  logic [31:0] cache_waddr_o;
  logic [7:0]  cache_wdata_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ram [256];

  // Reference model: phase 0 = idle, 1..6 = current cycle Cn of a fill.
  int          p = 0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] exp_inst = 32'd0;
  logic        e_rd, e_we, e_iv;
  logic [31:0] wa;

  int          cyc = 0;
  int          cnt_we = 0, cnt_iv = 0, cnt_rd = 0, iv_cyc = -1;
  logic [31:0] last_waddr = 32'd0;

  icache_refill #(.ADDR_W(32), .FILL_BYTES(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .req_addr_i(req_addr_i),
    .flush_i(flush_i), .mem_busy_i(mem_busy_i), .mem_a_o(mem_a_o), .mem_rd_o(mem_rd_o),
    .mem_din_i(mem_din_i), .cache_we_o(cache_we_o), .cache_waddr_o(cache_waddr_o),
    .cache_wdata_o(cache_wdata_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rb(input logic [31:0] a);
    return ram[a[7:0]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RAM model: registered read, frozen along with the rest of the system when rdy is low.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_o) mem_din_i <= ram[mem_a_o[7:0]];
  end

  // Per-cycle compare against the model, then advance the model on this cycle's inputs.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem_a", mem_a_o, 32'd0);
      chk("rst_mem_rd", {31'd0, mem_rd_o}, 32'd0);
      chk("rst_we", {31'd0, cache_we_o}, 32'd0);
      chk("rst_waddr", cache_waddr_o, 32'd0);
      chk("rst_wdata", {24'd0, cache_wdata_o}, 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_iv", {31'd0, inst_valid_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      p = 0;
      exp_inst = 32'd0;
    end else begin
      if (p == 6) exp_inst = {rb(m_a + 32'd3), rb(m_a + 32'd2), rb(m_a + 32'd1), rb(m_a)};
      e_rd = rdy && p >= 1 && p <= 4;
      e_we = rdy && p >= 3;
      e_iv = rdy && p == 6;
      chk("busy", {31'd0, busy_o}, {31'd0, p != 0});
      chk("mem_rd", {31'd0, mem_rd_o}, {31'd0, e_rd});
      chk("cache_we", {31'd0, cache_we_o}, {31'd0, e_we});
      chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, e_iv});
      chk("inst", inst_o, exp_inst);
      if (e_rd) chk("mem_a", mem_a_o, m_a + 32'(p - 1));
      if (e_we) begin
        wa = m_a + 32'(p - 3);
        chk("waddr", cache_waddr_o, wa);
        chk("wdata", {24'd0, cache_wdata_o}, {24'd0, rb(wa)});
      end
      if (cache_we_o) begin
        cnt_we++;
        last_waddr = cache_waddr_o;
      end
      if (inst_valid_o) begin
        cnt_iv++;
        iv_cyc = cyc;
      end
      if (mem_rd_o) cnt_rd++;
      if (rdy) begin
        if (p == 0) begin
          if (req_i && !mem_busy_i && !flush_i) begin
            p = 1;
            m_a = req_addr_i & ~32'h3;
          end
        end else if (flush_i || p == 6) begin
          p = 0;
        end else begin
          p++;
        end
      end
    end
  end

  task automatic fill_start(input logic [31:0] a, output int e0);
    req_i = 1'b1;
    req_addr_i = a;
    step();
    req_i = 1'b0;
    e0 = cyc;
  endtask

  initial begin
    int e0, w0, i0, r0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Basic fill
    w0 = cnt_we; i0 = cnt_iv;
    fill_start(32'h1002, e0);
    repeat (8) step();
    chk("t1_writes", 32'(cnt_we - w0), 32'd4);
    chk("t1_pulses", 32'(cnt_iv - i0), 32'd1);
    chk("t1_inst", inst_o, 32'h00100513);
    chk("t1_iv_cycle", 32'(iv_cyc - e0), 32'd5);
    chk("t1_last_waddr", last_waddr, 32'h1003);

    // Stall for 3 cycles starting C3
    w0 = cnt_we; i0 = cnt_iv;
    fill_start(32'h1000, e0);
    step(); step();
    rdy = 1'b0;
    repeat (3) step();
    rdy = 1'b1;
    repeat (10) step();
    chk("t2_writes", 32'(cnt_we - w0), 32'd4);
    chk("t2_pulses", 32'(cnt_iv - i0), 32'd1);
    chk("t2_iv_cycle", 32'(iv_cyc - e0), 32'd8);

    // Flush in C4
    w0 = cnt_we; i0 = cnt_iv;
    fill_start(32'h1000, e0);
    repeat (3) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("t3_busy_c5", {31'd0, busy_o}, 32'd0);
    repeat (8) step();
    chk("t3_writes", 32'(cnt_we - w0), 32'd2);
    chk("t3_pulses", 32'(cnt_iv - i0), 32'd0);
    chk("t3_last_waddr", last_waddr, 32'h1001);

    // Flush wins over request in IDLE
    req_i = 1'b1; flush_i = 1'b1; req_addr_i = 32'h1000;
    repeat (3) step();
    chk("flush_req_busy", {31'd0, busy_o}, 32'd0);
    req_i = 1'b0; flush_i = 1'b0;
    step();

    // Arbitration
    r0 = cnt_rd;
    mem_busy_i = 1'b1; req_i = 1'b1; req_addr_i = 32'h1000;
    repeat (5) step();
    chk("t4_no_reads", 32'(cnt_rd - r0), 32'd0);
    chk("t4_busy", {31'd0, busy_o}, 32'd0);
    mem_busy_i = 1'b0;
    step();
    req_i = 1'b0;
    chk("t4_rd_c1", {31'd0, mem_rd_o}, 32'd1);
    chk("t4_addr_c1", mem_a_o, 32'h1000);
    repeat (8) step();

    // Reset in C3, then a normal fill
    w0 = cnt_we;
    fill_start(32'h1000, e0);
    step(); step();
    rst = 1'b1;
    #1;
    chk("t5_we", {31'd0, cache_we_o}, 32'd0);
    chk("t5_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_inst", inst_o, 32'd0);
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("t5_writes", 32'(cnt_we - w0), 32'd0);
    i0 = cnt_iv;
    fill_start(32'h1002, e0);
    repeat (8) step();
    chk("t5_pulses", 32'(cnt_iv - i0), 32'd1);
    chk("t5_inst_after", inst_o, 32'h00100513);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rdy        = ($urandom % 8) != 0;
      req_i      = ($urandom % 3) == 0;
      mem_busy_i = ($urandom % 4) == 0;
      flush_i    = ($urandom % 12) == 0;
      req_addr_i = $urandom;
      rst        = ($urandom % 500) == 0;
      step();
    end
    rst = 1'b0; rdy = 1'b1; req_i = 1'b0; mem_busy_i = 1'b0; flush_i = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
